mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single instruction/data memory port between the ICache miss path and the DCache miss/write path. Each cache raises a one-cycle request pulse. The arbiter latches it, grants the port round-robin, and runs one outstanding memory transaction at a time. It routes the memory response back to the owning cache and aborts any transaction that outlives a watchdog limit.

## Interface
- TIMEOUT_CYCLES, 255: cycles allowed in ISSUE+WAIT before abort; minimum 2.
- TW, 8: watchdog counter width; must hold TIMEOUT_CYCLES.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  ICache request pulse.
- i_req_addr  in  32  ICache address, sampled with the pulse.
- i_resp_valid  out  1  one-cycle response strobe to ICache.
- i_resp_data  out  32  response data to ICache.
- d_req_valid  in  1  DCache request pulse.
- d_req_addr  in  32  DCache address.
- d_req_we  in  1  1 = write, 0 = read.
- d_req_wdata  in  32  DCache write data.
- d_resp_valid  out  1  one-cycle response strobe to DCache; for writes this is the ack.
- d_resp_data  out  32  response data to DCache.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  32  granted address.
- mem_req_we  out  1  granted write enable; always 0 for ICache.
- mem_req_wdata  out  32  granted write data; 0 for ICache.
- mem_resp_valid  in  1  memory completion.
- mem_resp_data  in  32  memory read data.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- Capture: a high x_req_valid sets pend_x and latches the address (plus we/wdata for D) at the clock edge.
  - A pulse while pend_x is already set is ignored; the latched fields are not overwritten.
  - If set and clear of pend_x occur on the same edge, set wins.
- Arbitration, in IDLE only:
  - One pend bit set: grant that requester.
  - Both set: grant the requester that is not last_grant.
  - last_grant resets to D, so I wins the first tie.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE -> ISSUE when any pend bit is set. On this transition, load the mem_req_* registers from the winner, record owner, and clear the watchdog.
  - ISSUE: mem_req_valid=1 and mem_req_* held stable. On mem_req_ready, go to WAIT.
  - WAIT: on mem_resp_valid, register mem_resp_data into the owner's resp_data, pulse the owner's resp_valid, clear pend_owner, set last_grant=owner, go to IDLE.
- The non-owner's resp_valid stays 0. The non-owner's resp_data holds its last value.
- mem_resp_valid is ignored in IDLE and ISSUE.
- Watchdog: counts every cycle in ISSUE or WAIT. When it reaches TIMEOUT_CYCLES-1 without completing:
  - set timeout_err (sticky until reset);
  - deliver a response to the owner with data 32'h0, clear pend_owner, and go to IDLE;
  - a completion in that same cycle wins, and timeout_err is not set.
- Reset, asynchronous and also mid-transaction:
  - state=IDLE, pend bits=0, last_grant=D, watchdog=0;
  - all outputs 0;
  - the abandoned transaction produces no response.

## Timing
- Pulse in cycle N: pend set at the end of N, ISSUE entered at the end of N+1, mem_req_valid=1 in cycle N+2.
- With mem_req_ready=1 in N+2, WAIT starts in N+3.
- mem_resp_valid in cycle M: x_resp_valid=1 and data valid in M+1; state is IDLE in M+1.
- Next mem_req_valid is no earlier than M+2, giving 1 idle cycle between back-to-back transactions.
- At most one outstanding memory transaction. mem_req_valid never drops before mem_req_ready.
- Responses are registered. There is no combinational path from mem_* inputs to the cache outputs.

## Test plan
- ICache-only read:
  - Stimulus: I pulse at cycle 1, addr 0x0000_0100; ready=1; mem_resp_valid at cycle 5 with data 0xDEAD_BEEF.
  - Required: mem_req_valid in cycle 3 only, mem_req_addr=0x100, we=0; i_resp_valid in cycle 6 with 0xDEAD_BEEF; d_resp_valid stays 0.
- Simultaneous pulses after reset:
  - Stimulus: I addr 0x40 and D write addr 0x80 / data 0x1234_5678, same cycle.
  - Required: I is served first; D is issued next with we=1, wdata=0x1234_5678; the D ack arrives after the I response.
- Fairness:
  - Stimulus: both requesters re-pulse immediately after each of their responses, for 6 transactions.
  - Required: grants alternate I, D, I, D, I, D.
- Backpressure:
  - Stimulus: mem_req_ready held 0 for 4 cycles.
  - Required: mem_req_valid/addr/we/wdata stable across all ISSUE cycles; WAIT entered only after the ready cycle.
- Watchdog:
  - Setup: TIMEOUT_CYCLES=8; memory never responds to a D read.
  - Required: d_resp_valid=1 with data 0 exactly 8 cycles after ISSUE entry; timeout_err=1 and stays 1; a subsequent I request completes normally.
- Reset mid-WAIT:
  - Stimulus: assert reset low asynchronously during WAIT.
  - Required: all outputs 0 immediately; after release, no stale response; a fresh request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between the ICache and DCache miss paths.
// Round-robin grant, one transaction in flight, watchdog abort.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TW             = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req_valid,
   input  logic [31:0] i_req_addr,
   output logic        i_resp_valid,
   output logic [31:0] i_resp_data,
   input  logic        d_req_valid,
   input  logic [31:0] d_req_addr,
   input  logic        d_req_we,
   input  logic [31:0] d_req_wdata,
   output logic        d_resp_valid,
   output logic [31:0] d_resp_data,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_we,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_pend_i;
   logic          r_pend_d;
   logic          r_last_d;
   logic          r_own_d;
   logic [31:0]   r_i_addr;
   logic [31:0]   r_d_addr;
   logic          r_d_we;
   logic [31:0]   r_d_wdata;
   logic [31:0]   r_m_addr;
   logic          r_m_we;
   logic [31:0]   r_m_wdata;
   logic [TW-1:0] r_wdog;
   logic          r_i_rv;
   logic [31:0]   r_i_rd;
   logic          r_d_rv;
   logic [31:0]   r_d_rd;
   logic          r_terr;

   logic w_grant_d;
   logic w_start;
   logic w_expire;
   logic w_done;
   logic w_abort;
   logic w_fin;
   logic w_clr_i;
   logic w_clr_d;
   logic w_set_i;
   logic w_set_d;

   // On a tie the requester that was not served last wins
   assign w_grant_d = r_pend_d & (~r_pend_i | ~r_last_d);
   assign w_start   = (r_state == IDLE) & (r_pend_i | r_pend_d);
   assign w_expire  = (r_wdog == TW'(TIMEOUT_CYCLES - 1));
   assign w_done    = (r_state == WAIT) & mem_resp_valid;
   assign w_abort   = (r_state != IDLE) & w_expire & ~w_done;
   assign w_fin     = w_done | w_abort;
   assign w_clr_i   = w_fin & ~r_own_d;
   assign w_clr_d   = w_fin & r_own_d;
   assign w_set_i   = i_req_valid & (~r_pend_i | w_clr_i);
   assign w_set_d   = d_req_valid & (~r_pend_d | w_clr_d);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_start) w_next = ISSUE;
         end
         ISSUE: begin
            if (w_abort)            w_next = IDLE;
            else if (mem_req_ready) w_next = WAIT;
         end
         WAIT: begin
            if (w_fin) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_i  <= 1'b0;
         r_pend_d  <= 1'b0;
         r_i_addr  <= '0;
         r_d_addr  <= '0;
         r_d_we    <= 1'b0;
         r_d_wdata <= '0;
      end else begin
         r_pend_i <= w_set_i | (r_pend_i & ~w_clr_i);
         r_pend_d <= w_set_d | (r_pend_d & ~w_clr_d);
         if (w_set_i) r_i_addr <= i_req_addr;
         if (w_set_d) begin
            r_d_addr  <= d_req_addr;
            r_d_we    <= d_req_we;
            r_d_wdata <= d_req_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_own_d   <= 1'b0;
         r_last_d  <= 1'b1;
         r_m_addr  <= '0;
         r_m_we    <= 1'b0;
         r_m_wdata <= '0;
         r_wdog    <= '0;
      end else begin
         if (w_start) begin
            r_own_d   <= w_grant_d;
            r_m_addr  <= w_grant_d ? r_d_addr : r_i_addr;
            r_m_we    <= w_grant_d & r_d_we;
            r_m_wdata <= w_grant_d ? r_d_wdata : '0;
            r_wdog    <= '0;
         end else if (r_state != IDLE) begin
            r_wdog <= r_wdog + TW'(1);
         end
         if (w_done) r_last_d <= r_own_d;
      end
   end

   // Aborted transactions still answer the owner, with zero data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_i_rv <= 1'b0;
         r_i_rd <= '0;
         r_d_rv <= 1'b0;
         r_d_rd <= '0;
         r_terr <= 1'b0;
      end else begin
         r_i_rv <= w_clr_i;
         r_d_rv <= w_clr_d;
         if (w_clr_i) r_i_rd <= w_done ? mem_resp_data : '0;
         if (w_clr_d) r_d_rd <= w_done ? mem_resp_data : '0;
         r_terr <= r_terr | w_abort;
      end
   end

   assign mem_req_valid = (r_state == ISSUE);
   assign mem_req_addr  = r_m_addr;
   assign mem_req_we    = r_m_we;
   assign mem_req_wdata = r_m_wdata;
   assign i_resp_valid  = r_i_rv;
   assign i_resp_data   = r_i_rd;
   assign d_resp_valid  = r_d_rv;
   assign d_resp_data   = r_d_rd;
   assign busy          = (r_state != IDLE);
   assign timeout_err   = r_terr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus hand sequences, with a
// response scoreboard and a grant-order scoreboard.
module tb_mem_arbiter;

   localparam logic [31:0] K = 32'hDEAD_BFEF;

   typedef struct {
      bit          vi;
      logic [31:0] ia;
      bit          vd;
      bit          we;
      logic [31:0] da;
      logic [31:0] wd;
      int          bp;
      int          lat;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        i_req_valid;
   logic [31:0] i_req_addr;
   logic        i_resp_valid;
   logic [31:0] i_resp_data;
   logic        d_req_valid;
   logic [31:0] d_req_addr;
   logic        d_req_we;
   logic [31:0] d_req_wdata;
   logic        d_resp_valid;
   logic [31:0] d_resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        busy;
   logic        timeout_err;

   mem_arbiter #(.TIMEOUT_CYCLES(8), .TW(8)) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
      .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr),
      .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .busy(busy), .timeout_err(timeout_err)
   );

   logic [133:0] outs;
   assign outs = {i_resp_valid, i_resp_data, d_resp_valid, d_resp_data,
                  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
                  busy, timeout_err};

   int ntests = 0;
   int nfail  = 0;

   logic [31:0] qi[$];
   logic [31:0] qd[$];
   logic [64:0] eg[$];
   logic [31:0] m_i_data = '0;
   logic [31:0] m_d_data = '0;
   bit          m_last_d = 1'b1;

   int m_bp     = 0;
   int m_lat    = 0;
   bit m_silent = 1'b0;

   vec_t vecs[7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [95:0] act,
                      input logic [95:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic fail_unexp(input string nm, input logic [95:0] act);
      ntests++;
      nfail++;
      $display("FAIL %s: got %h, required nothing pending", nm, act);
   endtask

   // Memory model: ready after m_bp cycles, response m_lat cycles later
   initial begin
      logic [31:0] a;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         tick();
         if (mem_req_valid && reset) begin
            repeat (m_bp) tick();
            mem_req_ready = 1'b1;
            a = mem_req_addr;
            tick();
            mem_req_ready = 1'b0;
            if (!m_silent) begin
               repeat (m_lat) tick();
               mem_resp_valid = 1'b1;
               mem_resp_data  = a ^ K;
               tick();
               mem_resp_valid = 1'b0;
               mem_resp_data  = '0;
            end
         end
      end
   end

   logic        p_v = 1'b0;
   logic        p_r = 1'b0;
   logic [64:0] p_f = '0;
   logic [31:0] mon_e;

   always @(negedge clk) begin
      if (!reset) begin
         p_v = 1'b0;
      end else begin
         if (i_resp_valid || d_resp_valid)
            chk("resp_exclusive", i_resp_valid & d_resp_valid, 0);
         if (i_resp_valid) begin
            if (qi.size() == 0) fail_unexp("i_resp_unexpected", i_resp_data);
            else begin
               mon_e = qi.pop_front();
               chk("i_resp_data", i_resp_data, mon_e);
               chk("d_data_hold", d_resp_data, m_d_data);
               m_i_data = mon_e;
            end
         end
         if (d_resp_valid) begin
            if (qd.size() == 0) fail_unexp("d_resp_unexpected", d_resp_data);
            else begin
               mon_e = qd.pop_front();
               chk("d_resp_data", d_resp_data, mon_e);
               chk("i_data_hold", i_resp_data, m_i_data);
               m_d_data = mon_e;
            end
         end
         if (mem_req_valid && mem_req_ready) begin
            if (eg.size() == 0)
               fail_unexp("grant_unexpected", mem_req_addr);
            else
               chk("grant", {mem_req_we, mem_req_addr, mem_req_wdata},
                   eg.pop_front());
         end
         if (p_v && !p_r) begin
            chk("req_valid_hold", mem_req_valid, 1);
            chk("req_fields_hold", {mem_req_we, mem_req_addr, mem_req_wdata}, p_f);
         end
         p_v = mem_req_valid;
         p_r = mem_req_ready;
         p_f = {mem_req_we, mem_req_addr, mem_req_wdata};
      end
   end

   task automatic wait_drain();
      int n;
      n = 0;
      while (!(qi.size() == 0 && qd.size() == 0 && eg.size() == 0 && !busy)
             && n < 100) begin
         tick();
         n++;
      end
      chk("drain", n < 100, 1);
   endtask

   task automatic run_vec(input vec_t v);
      logic [64:0] gi;
      logic [64:0] gd;
      m_bp  = v.bp;
      m_lat = v.lat;
      gi = {1'b0, v.ia, 32'h0};
      gd = {v.we, v.da, v.wd};
      tick();
      i_req_valid = v.vi;
      i_req_addr  = v.ia;
      d_req_valid = v.vd;
      d_req_addr  = v.da;
      d_req_we    = v.we;
      d_req_wdata = v.wd;
      if (v.vi) qi.push_back(v.ia ^ K);
      if (v.vd) qd.push_back(v.da ^ K);
      if (v.vi && v.vd) begin
         if (m_last_d) begin
            eg.push_back(gi); eg.push_back(gd); m_last_d = 1'b1;
         end else begin
            eg.push_back(gd); eg.push_back(gi); m_last_d = 1'b0;
         end
      end else if (v.vi) begin
         eg.push_back(gi); m_last_d = 1'b0;
      end else if (v.vd) begin
         eg.push_back(gd); m_last_d = 1'b1;
      end
      tick();
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      wait_drain();
   endtask

   task automatic clear_model();
      qi.delete();
      qd.delete();
      eg.delete();
      m_i_data = '0;
      m_d_data = '0;
      m_last_d = 1'b1;
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b0;
      clear_model();
      repeat (3) tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      logic [7:1] mv, ir, dr;
      logic [31:0] a3;
      logic        w3;
      int ni, nd, ci, cd, n, cv, cr, ti, tr;
      bit first_d, dturn;
      vec_t v;

      vecs[0] = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 0, 0};
      vecs[1] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,         1, 2};
      vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h88, 32'h0,         0, 3};
      vecs[3] = '{1'b1, 32'h48, 1'b1, 1'b0, 32'h8C, 32'h0,         2, 2};
      vecs[4] = '{1'b1, 32'h4C, 1'b0, 1'b0, 32'h0,  32'h0,         0, 1};
      vecs[5] = '{1'b1, 32'h50, 1'b1, 1'b1, 32'h90, 32'hCAFE_F00D, 1, 0};
      vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h94, 32'h0,         3, 3};

      reset = 1'b0;
      i_req_valid = 1'b0; i_req_addr = '0;
      d_req_valid = 1'b0; d_req_addr = '0;
      d_req_we = 1'b0; d_req_wdata = '0;
      repeat (3) tick();
      chk("reset_outs", |outs, 0);
      reset = 1'b1;
      repeat (2) tick();
      chk("idle_outs", |outs, 0);

      // ICache-only read with exact cycle positions
      m_bp = 0; m_lat = 1;
      tick();
      i_req_valid = 1'b1;
      i_req_addr  = 32'h100;
      qi.push_back(32'hDEAD_BEEF);
      eg.push_back({1'b0, 32'h100, 32'h0});
      m_last_d = 1'b0;
      a3 = '0; w3 = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         mv[c] = mem_req_valid;
         ir[c] = i_resp_valid;
         dr[c] = d_resp_valid;
         if (c == 3) begin a3 = mem_req_addr; w3 = mem_req_we; end
         tick();
         if (c == 1) i_req_valid = 1'b0;
      end
      chk("icache_req_cycle", mv, 7'b0000100);
      chk("icache_resp_cycle", ir, 7'b0100000);
      chk("icache_no_dresp", dr, 7'b0000000);
      chk("icache_addr", a3, 32'h100);
      chk("icache_we", w3, 0);
      wait_drain();

      do_reset();
      for (int k = 0; k < 7; k++) run_vec(vecs[k]);
      chk("terr_boundary", timeout_err, 0);

      // Fairness: both re-pulse in their response cycle
      m_bp = 0; m_lat = 0;
      first_d = ~m_last_d;
      ci = 0; cd = 0;
      for (int k = 0; k < 6; k++) begin
         dturn = first_d ^ k[0];
         if (dturn) begin
            eg.push_back({1'b0, 32'h2000 + 32'(4 * cd), 32'h0}); cd++;
         end else begin
            eg.push_back({1'b0, 32'h1000 + 32'(4 * ci), 32'h0}); ci++;
         end
      end
      tick();
      i_req_valid = 1'b1; i_req_addr = 32'h1000;
      d_req_valid = 1'b1; d_req_addr = 32'h2000;
      d_req_we = 1'b0; d_req_wdata = '0;
      qi.push_back(32'h1000 ^ K);
      qd.push_back(32'h2000 ^ K);
      ni = 1; nd = 1; n = 0;
      while (!(ni == 3 && nd == 3 && qi.size() == 0 && qd.size() == 0 &&
               !busy) && n < 300) begin
         tick();
         n++;
         i_req_valid = 1'b0;
         d_req_valid = 1'b0;
         if (i_resp_valid && ni < 3) begin
            i_req_valid = 1'b1;
            i_req_addr  = 32'h1000 + 32'(4 * ni);
            qi.push_back(i_req_addr ^ K);
            ni++;
         end
         if (d_resp_valid && nd < 3) begin
            d_req_valid = 1'b1;
            d_req_addr  = 32'h2000 + 32'(4 * nd);
            qd.push_back(d_req_addr ^ K);
            nd++;
         end
      end
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      chk("fair_done", n < 300, 1);
      chk("fair_grants_left", eg.size(), 0);
      m_last_d = ~first_d;

      // Backpressure: ready held low for 4 ISSUE cycles
      m_bp = 4; m_lat = 0;
      tick();
      d_req_valid = 1'b1; d_req_addr = 32'h400;
      d_req_we = 1'b1; d_req_wdata = 32'hA5A5_5A5A;
      qd.push_back(32'h400 ^ K);
      eg.push_back({1'b1, 32'h400, 32'hA5A5_5A5A});
      m_last_d = 1'b1;
      tick();
      d_req_valid = 1'b0;
      cv = 0; cr = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         cv += int'(mem_req_valid);
         cr += int'(mem_req_valid && mem_req_ready);
      end
      chk("bp_issue_cycles", cv, 5);
      chk("bp_ready_cycles", cr, 1);
      wait_drain();

      // Watchdog: D read accepted but never answered
      m_silent = 1'b1; m_bp = 0;
      chk("terr_pre", timeout_err, 0);
      tick();
      d_req_valid = 1'b1; d_req_addr = 32'h500;
      d_req_we = 1'b0; d_req_wdata = '0;
      qd.push_back(32'h0);
      eg.push_back({1'b0, 32'h500, 32'h0});
      tick();
      d_req_valid = 1'b0;
      ti = -1; tr = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ti < 0 && mem_req_valid) ti = c;
         if (tr < 0 && d_resp_valid) tr = c;
      end
      chk("wd_resp_seen", tr >= 0, 1);
      chk("wd_latency", 32'(tr - ti), 32'd8);
      chk("terr_set", timeout_err, 1);
      m_silent = 1'b0;
      v = '{1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1};
      run_vec(v);
      chk("terr_sticky", timeout_err, 1);

      // Asynchronous reset in WAIT
      m_bp = 0; m_lat = 3;
      tick();
      i_req_valid = 1'b1; i_req_addr = 32'h700;
      qi.push_back(32'h700 ^ K);
      eg.push_back({1'b0, 32'h700, 32'h0});
      tick();
      i_req_valid = 1'b0;
      n = 0;
      while (!(busy && !mem_req_valid) && n < 20) begin
         tick();
         n++;
      end
      chk("reach_wait", n < 20, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_outs", |outs, 0);
      clear_model();
      repeat (4) tick();
      reset = 1'b1;
      repeat (8) tick();
      chk("post_reset_idle", busy, 0);
      chk("post_reset_terr", timeout_err, 0);
      v = '{1'b1, 32'h740, 1'b1, 1'b0, 32'h780, 32'h0, 0, 0};
      run_vec(v);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
